// File: rtl/serial_adder.sv
// ============================================================================
//  Module   : serial_adder
//  Brief    : Bit-serial LSB-first ripple adder built from one full-adder cell
//             and a carry flop. Optional subtract mode via SERIAL_ADDER_SUB_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic             ha_p;
    logic             ha_g;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;
    logic             cout_final;

    // Full adder as two half-adder stages: (a0,b0) then (p,carry).
    assign ha_p     = a_sh[0] ^ b_sh[0];
    assign ha_g     = a_sh[0] & b_sh[0];
    assign fa_s     = ha_p ^ carry;
    assign fa_c     = ha_g | (ha_p & carry);
    assign res_next = {fa_s, res_sh};

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_r;
    // In subtract mode the final carry is inverted to report a borrow.
    assign cout_final = fa_c ^ sub_r;
`else
    assign cout_final = fa_c;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        sub_r <= sub;
`else
                        b_sh  <= b;
                        carry <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    carry  <= fa_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= cout_final;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Scoreboard bench for serial_adder (WIDTH=8), directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse in the current cycle and queues its expected result.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts, input logic [8:0] exp_v);
        a     = ta;
        b     = tb_v;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = ts;
`else
        if (ts) $display("note: subtract vector skipped");
`endif
        start = 1'b1;
        exp_q.push_back(exp_v);
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("result_sum", 32'(sum), 32'(e[7:0]));
                    check("result_cout", 32'(cout), 32'(e[8]));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();

        // 0x3C + 0x0F with full cycle-by-cycle timing
        issue(8'h3C, 8'h0F, 1'b0, {1'b0, 8'h4B});
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'd1);
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'd0);
            tick();
        end
        check("t1_done_c9", 32'(done), 32'd1);
        check("t1_busy_c9", 32'(busy), 32'd0);
        tick();
        check("t1_done_c10", 32'(done), 32'd0);
        drain("t1");

        // 0xFF + 0x01 overflow, result held in IDLE
        issue(8'hFF, 8'h01, 1'b0, {1'b1, 8'h00});
        drain("t2");
        repeat (5) tick();
        check("t2_hold_sum", 32'(sum), 32'h00);
        check("t2_hold_cout", 32'(cout), 32'd1);

        // Second start during RUN is ignored; operands change mid-run
        issue(8'h10, 8'h20, 1'b0, {1'b0, 8'h30});
        repeat (3) tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0; a = 8'hC3; b = 8'h7E;
        drain("t3");
        repeat (12) tick();
        check("t3_idle_busy", 32'(busy), 32'd0);

        // Reset mid-run discards the operation
        issue(8'h81, 8'h81, 1'b0, {1'b1, 8'h02});
        repeat (3) tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_sum", 32'(sum), 32'd0);
        check("t4_rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        repeat (12) tick();
        check("t4_no_done", 32'(done), 32'd0);
        issue(8'h81, 8'h81, 1'b0, {1'b1, 8'h02});
        drain("t4");
        tick();

        // start held high: accepted in cycles 0 and 10
        a = 8'h12; b = 8'h34; start = 1'b1;
        exp_q.push_back({1'b0, 8'h46});
        exp_q.push_back({1'b1, 8'h10});
        tick();
        a = 8'hF0; b = 8'h20;
        for (int c = 1; c <= 19; c++) begin
            check($sformatf("t5_busy_c%0d", c), 32'(busy),
                  32'(((c >= 1 && c <= 8) || (c >= 11 && c <= 18)) ? 1 : 0));
            check($sformatf("t5_done_c%0d", c), 32'(done),
                  32'((c == 9 || c == 19) ? 1 : 0));
            if (c == 11) start = 1'b0;
            tick();
        end
        drain("t5");

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h05, 8'h07, 1'b1, {1'b1, 8'hFE});
        drain("t6a");
        issue(8'h07, 8'h05, 1'b1, {1'b0, 8'h02});
        drain("t6b");
        issue(8'h07, 8'h05, 1'b0, {1'b0, 8'h0C});
        drain("t6c");
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
